// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : opcodes, ALU op codes, FSM states and control bundle for control_fsm
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [1:0] {
    ST_EXEC      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_HALT      = 2'd2
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       mem2reg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [3:0] aluctl;
  } ctl_t;

endpackage : ctrl_pkg

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// ============================================================================
// ctrl_decoder : combinational RV32 subset decoder; anything unrecognised halts
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctl_t        o_ctl,
  output logic        o_is_load,
  output logic        o_is_halt
);

  logic [6:0] w_opcode;
  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  ctl_t       w_ctl;
  logic       w_legal;
  logic       w_load;
  logic       w_ecall;
  logic       w_unused_fields;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register specifiers only matter to the datapath.
  assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7], w_ecall};
  // ECALL and illegal words share the same halt path; kept for clarity.
  assign w_ecall = (i_instr == ECALL_WORD);

  always_comb begin
    w_ctl   = '0;
    w_legal = 1'b0;
    w_load  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_ctl.regwrite = 1'b1;
        w_legal        = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_ctl.aluctl = ALU_ADD;
          {7'b0100000, 3'b000}: w_ctl.aluctl = ALU_SUB;
          {7'b0000000, 3'b111}: w_ctl.aluctl = ALU_AND;
          {7'b0000000, 3'b110}: w_ctl.aluctl = ALU_OR;
          {7'b0000000, 3'b010}: w_ctl.aluctl = ALU_SLT;
          default:              w_legal      = 1'b0;
        endcase
      end
      OP_I: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.alusrc   = 1'b1;
        w_legal        = 1'b1;
        case (w_funct3)
          3'b000:  w_ctl.aluctl = ALU_ADD;
          3'b111:  w_ctl.aluctl = ALU_AND;
          3'b110:  w_ctl.aluctl = ALU_OR;
          3'b010:  w_ctl.aluctl = ALU_SLT;
          default: w_legal      = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (w_funct3 == 3'b010) begin
          w_ctl.mem2reg = 1'b1;
          w_ctl.alusrc  = 1'b1;
          w_ctl.aluctl  = ALU_ADD;
          w_load        = 1'b1;
          w_legal       = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b010) begin
          w_ctl.memwrite = 1'b1;
          w_ctl.alusrc   = 1'b1;
          w_ctl.aluctl   = ALU_ADD;
          w_legal        = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == 3'b000) begin
          w_ctl.branch = 1'b1;
          w_ctl.aluctl = ALU_SUB;
          w_legal      = 1'b1;
        end
      end
      OP_JAL, OP_JALR: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.aluctl   = ALU_ADD;
        w_legal        = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.alusrc   = 1'b1;
        w_ctl.aluctl   = ALU_ADD;
        w_legal        = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign o_ctl     = w_legal ? w_ctl : '0;
  assign o_is_load = w_legal & w_load;
  assign o_is_halt = ~w_legal;

endmodule : ctrl_decoder

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// control_fsm : sequencing control for the single-cycle RISC-V datapath
//               optional perf counters under `CTRL_PERF_CNT_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module control_fsm
  import ctrl_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             zero,
  output logic             branch,
  output logic             mem2reg,
  output logic             memwrite,
  output logic             alusrc,
  output logic             regwrite,
  output logic [3:0]       aluctl,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stalls
);

  state_t         r_state;
  state_t         w_next;
  ctl_t           w_dec;
  ctl_t           w_ctl;
  logic           w_is_load;
  logic           w_is_halt;
  logic           w_pc_en;
  logic           w_halted;
  logic [W-1:0]   w_unused_zero;

  // The zero flag is consumed only by the datapath's branch logic.
  assign w_unused_zero = {{(W-1){1'b0}}, zero};

  ctrl_decoder u_decoder (
    .i_instr   (instruction),
    .o_ctl     (w_dec),
    .o_is_load (w_is_load),
    .o_is_halt (w_is_halt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EXEC;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ctl    = '0;
    w_pc_en  = 1'b0;
    w_halted = 1'b0;
    if (rst) begin
      case (r_state)
        ST_EXEC: begin
          if (w_is_halt) begin
            w_halted = 1'b1;
            w_next   = ST_HALT;
          end else if (w_is_load) begin
            w_ctl  = w_dec;
            w_next = ST_LOAD_WAIT;
          end else begin
            w_ctl   = w_dec;
            w_pc_en = 1'b1;
          end
        end
        ST_LOAD_WAIT: begin
          // Read data is now valid at the registered memory port.
          w_ctl.mem2reg  = 1'b1;
          w_ctl.alusrc   = 1'b1;
          w_ctl.regwrite = 1'b1;
          w_ctl.aluctl   = ALU_ADD;
          w_pc_en        = 1'b1;
          w_next         = ST_EXEC;
        end
        ST_HALT: begin
          w_halted = 1'b1;
        end
        default: begin
          w_next = ST_EXEC;
        end
      endcase
    end
  end

  assign branch   = w_ctl.branch;
  assign mem2reg  = w_ctl.mem2reg;
  assign memwrite = w_ctl.memwrite;
  assign alusrc   = w_ctl.alusrc;
  assign regwrite = w_ctl.regwrite;
  assign aluctl   = w_ctl.aluctl;
  assign pc_en    = w_pc_en;
  assign halted   = w_halted;

`ifdef CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stalls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
      r_stalls  <= '0;
    end else begin
      if (w_pc_en)                  r_retired <= r_retired + c_cnt_one;
      if (r_state == ST_LOAD_WAIT)  r_stalls  <= r_stalls + c_cnt_one;
    end
  end

  assign retired = r_retired;
  assign stalls  = r_stalls;
`else
  assign retired = '0;
  assign stalls  = '0;
`endif

endmodule : control_fsm

`default_nettype wire
